hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline interlock unit that drives the stall and flush controls of the PC, IF/OF, OF/ALU and ALU/MA pipeline registers. It detects load-use hazards between the OF and ALU stages, squashes wrong-path instructions on a taken branch, and holds the front of the pipe while a multi-cycle ALU operation runs. It also keeps saturating stall and flush event counters. It sits beside the pipeline registers and feeds their `stall_*` and `flush` inputs; those registers give stall precedence over flush.

## Interface
- `MC_LAT`, default 4: total ALU-stage occupancy of a multi-cycle op. Must be ≥ 2.
- `CNT_W`, default 32: width of the performance counters.

- `clk`  in  1  pipeline clock
- `rst_n`  in  1  asynchronous, active-low reset
- `RP1_OF`, `RP2_OF`  in  5 each  source register indices of the instruction in OF
- `readsRP1_OF`, `readsRP2_OF`  in  1 each  OF instruction actually reads that source
- `is_Ld_ALU`  in  1  ALU-stage instruction is a load
- `isWb_ALU`  in  1  ALU-stage instruction writes the register file
- `rd_ALU`  in  5  destination of the ALU-stage instruction
- `isBranchTaken_ALU`  in  1  resolved taken branch, call or ret in ALU
- `mcStart_ALU`  in  1  ALU-stage instruction is multi-cycle (held stable while stalled)
- `clrCnt`  in  1  synchronous clear of both counters
- `stall_PC`, `stall_IFOF`, `stall_OFALU`  out  1 each  hold the corresponding register
- `flush_IFOF`, `flush_OFALU`, `flush_ALUMA`  out  1 each  load a bubble into the corresponding register
- `mcBusy`  out  1  FSM is in MC_BUSY
- `mcDone`  out  1  final ALU cycle of a multi-cycle op
- `stallCount`, `flushCount`  out  CNT_W each  event counters

## Operation
- **FSM states:** IDLE and MC_BUSY. There is also a down-counter `mcCnt` of width $clog2(MC_LAT).
- **Load-use hazard:** `luHaz = is_Ld_ALU & isWb_ALU & ((readsRP1_OF & RP1_OF==rd_ALU) | (readsRP2_OF & RP2_OF==rd_ALU))`. No register is exempt.
- **IDLE, priority order:**
  1. `isBranchTaken_ALU` asserts `flush_IFOF=flush_OFALU=1` with no stall. This overrides `luHaz` and `mcStart_ALU`.
  2. `mcStart_ALU` asserts `stall_PC=stall_IFOF=stall_OFALU=1` and `flush_ALUMA=1`, loads `mcCnt<=MC_LAT-2`, and moves to MC_BUSY.
  3. `luHaz` asserts `stall_PC=stall_IFOF=1` and `flush_OFALU=1` (one bubble).
  4. Otherwise all outputs are 0.
- **MC_BUSY:**
  - `mcCnt!=0`: same four stall/flush outputs as the start cycle; `mcCnt` decrements.
  - `mcCnt==0`: `mcDone=1`, no stall or flush; return to IDLE.
  - `luHaz`, `isBranchTaken_ALU` and `mcStart_ALU` are ignored in this state.
- **Mutual exclusion:** `flush_X` and `stall_X` are never both 1 for the same register.
- **Counters:**
  - `stallCount` increments on every cycle with `stall_PC=1`.
  - `flushCount` increments on every cycle with `flush_IFOF=1`.
  - Both saturate at 2^CNT_W−1 (no wrap).
  - `clrCnt` zeroes both and wins over a simultaneous increment.

## Timing
- **Combinational outputs:** all stall, flush and `mcDone` outputs are combinational from inputs plus registered state, valid within the same cycle for the next `posedge clk`.
- **Registered state:** FSM, `mcCnt` and counters update on `posedge clk`.
- **Load-use:** costs exactly 1 stall cycle. On the next cycle the load has moved to MA, so `luHaz` drops.
- **Multi-cycle op started at cycle T:** stall is asserted for cycles T..T+MC_LAT−2; `mcDone` is high at T+MC_LAT−1; the FSM is in IDLE at T+MC_LAT. Back-to-back multi-cycle ops are accepted from T+MC_LAT.
- **Branch flush:** occupies 1 cycle, leaving 2 bubbles (IF/OF and OF/ALU).
- **Reset:**
  - While `rst_n=0`, all outputs are 0, the FSM is in IDLE, and `mcCnt` and both counters are 0.
  - Reset asserted mid multi-cycle op abandons the op immediately; there is no `mcDone`.
  - Deassertion is synchronised externally. The first edge after release evaluates IDLE.

## Structure
- **Shared package `pipe_pkg`:**
  - FSM state enum `hz_state_t` {IDLE, MC_BUSY}
  - register index width constant `REG_IDX_W=5`
  - default `MC_LAT`
- **Sub-module `sat_counter`:** one natural sub-module, parameterised by width, with `inc` and `clr` inputs. Instantiated twice.
- **Top level:** everything else stays in `hazard_ctrl`.

## Test plan
- **Load-use:** `is_Ld_ALU=1`, `isWb_ALU=1`, `rd_ALU=3`, `RP2_OF=3`, `readsRP2_OF=1` → one cycle of `stall_PC=stall_IFOF=1`, `flush_OFALU=1`, `stallCount` goes 0→1. The same case with `readsRP2_OF=0` → no stall.
- **Branch vs load-use:** `isBranchTaken_ALU=1` together with a load-use match → `flush_IFOF=flush_OFALU=1`, all stalls 0, `flushCount` +1.
- **Multi-cycle op:** `MC_LAT=4`, `mcStart_ALU` pulsed at T and held → stalls and `flush_ALUMA` high at T, T+1, T+2; `mcDone=1` at T+3; `mcBusy` high at T+1..T+3; `stallCount=3`.
- **Reset mid-op:** in MC_BUSY with `mcCnt=1`, drop `rst_n` → all outputs 0 immediately, no `mcDone`, counters 0, IDLE after release.
- **Saturation and clear:** with `CNT_W=4`, 20 load-use cycles → `stallCount=15`. Then `clrCnt` together with a stall cycle → `stallCount=0`.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline-control types and constants for the hazard/interlock logic.
package pipe_pkg;

    localparam int REG_IDX_W   = 5;
    localparam int MC_LAT_DFLT = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        MC_BUSY = 1'b1
    } hz_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; updates one cycle after inc/clr.
// Clear has priority over increment, and the count holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline interlock: load-use stall, taken-branch squash, multi-cycle ALU hold, event counters.
// Stall/flush controls are combinational in the same cycle; state and counters update on posedge clk.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MC_LAT = MC_LAT_DFLT,
    parameter int CNT_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_IDX_W-1:0] RP1_OF,
    input  logic [REG_IDX_W-1:0] RP2_OF,
    input  logic                 readsRP1_OF,
    input  logic                 readsRP2_OF,
    input  logic                 is_Ld_ALU,
    input  logic                 isWb_ALU,
    input  logic [REG_IDX_W-1:0] rd_ALU,
    input  logic                 isBranchTaken_ALU,
    input  logic                 mcStart_ALU,
    input  logic                 clrCnt,
    output logic                 stall_PC,
    output logic                 stall_IFOF,
    output logic                 stall_OFALU,
    output logic                 flush_IFOF,
    output logic                 flush_OFALU,
    output logic                 flush_ALUMA,
    output logic                 mcBusy,
    output logic                 mcDone,
    output logic [CNT_W-1:0]     stallCount,
    output logic [CNT_W-1:0]     flushCount
);

    localparam int MCW = $clog2(MC_LAT);

    hz_state_t      r_state;
    hz_state_t      w_state_nxt;
    logic [MCW-1:0] r_mc_cnt;
    logic [MCW-1:0] w_mc_cnt_nxt;
    logic           w_lu_haz;

    assign w_lu_haz = is_Ld_ALU & isWb_ALU &
                      ((readsRP1_OF & (RP1_OF == rd_ALU)) |
                       (readsRP2_OF & (RP2_OF == rd_ALU)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_mc_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_mc_cnt <= w_mc_cnt_nxt;
        end
    end

    // A taken branch squashes the ALU-stage instruction, so it never starts a multi-cycle op.
    always_comb begin
        w_state_nxt  = r_state;
        w_mc_cnt_nxt = r_mc_cnt;
        case (r_state)
            IDLE: begin
                if (!isBranchTaken_ALU && mcStart_ALU) begin
                    w_state_nxt  = MC_BUSY;
                    w_mc_cnt_nxt = MCW'(MC_LAT - 2);
                end
            end
            MC_BUSY: begin
                if (r_mc_cnt != '0) begin
                    w_mc_cnt_nxt = r_mc_cnt - MCW'(1);
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stall_PC    = 1'b0;
        stall_IFOF  = 1'b0;
        stall_OFALU = 1'b0;
        flush_IFOF  = 1'b0;
        flush_OFALU = 1'b0;
        flush_ALUMA = 1'b0;
        mcDone      = 1'b0;
        if (rst_n) begin
            case (r_state)
                IDLE: begin
                    if (isBranchTaken_ALU) begin
                        flush_IFOF  = 1'b1;
                        flush_OFALU = 1'b1;
                    end else if (mcStart_ALU) begin
                        stall_PC    = 1'b1;
                        stall_IFOF  = 1'b1;
                        stall_OFALU = 1'b1;
                        flush_ALUMA = 1'b1;
                    end else if (w_lu_haz) begin
                        stall_PC    = 1'b1;
                        stall_IFOF  = 1'b1;
                        flush_OFALU = 1'b1;
                    end
                end
                MC_BUSY: begin
                    if (r_mc_cnt != '0) begin
                        stall_PC    = 1'b1;
                        stall_IFOF  = 1'b1;
                        stall_OFALU = 1'b1;
                        flush_ALUMA = 1'b1;
                    end else begin
                        mcDone = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mcBusy = (r_state == MC_BUSY);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_PC),
        .clr   (clrCnt),
        .cnt   (stallCount)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_IFOF),
        .clr   (clrCnt),
        .cnt   (flushCount)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl (MC_LAT=4, CNT_W=4 so saturation is reachable).
module tb_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] RP1_OF, RP2_OF, rd_ALU;
    logic       readsRP1_OF, readsRP2_OF;
    logic       is_Ld_ALU, isWb_ALU, isBranchTaken_ALU, mcStart_ALU, clrCnt;
    logic       stall_PC, stall_IFOF, stall_OFALU;
    logic       flush_IFOF, flush_OFALU, flush_ALUMA;
    logic       mcBusy, mcDone;
    logic [3:0] stallCount, flushCount;

    int n_vec = 0;
    int n_err = 0;

    hazard_ctrl #(.MC_LAT(4), .CNT_W(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .RP1_OF            (RP1_OF),
        .RP2_OF            (RP2_OF),
        .readsRP1_OF       (readsRP1_OF),
        .readsRP2_OF       (readsRP2_OF),
        .is_Ld_ALU         (is_Ld_ALU),
        .isWb_ALU          (isWb_ALU),
        .rd_ALU            (rd_ALU),
        .isBranchTaken_ALU (isBranchTaken_ALU),
        .mcStart_ALU       (mcStart_ALU),
        .clrCnt            (clrCnt),
        .stall_PC          (stall_PC),
        .stall_IFOF        (stall_IFOF),
        .stall_OFALU       (stall_OFALU),
        .flush_IFOF        (flush_IFOF),
        .flush_OFALU       (flush_OFALU),
        .flush_ALUMA       (flush_ALUMA),
        .mcBusy            (mcBusy),
        .mcDone            (mcDone),
        .stallCount        (stallCount),
        .flushCount        (flushCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Packs the six stall/flush outputs plus mcDone: {sPC,sIFOF,sOFALU,fIFOF,fOFALU,fALUMA,done}
    function automatic logic [31:0] ctl();
        return {25'd0, stall_PC, stall_IFOF, stall_OFALU,
                flush_IFOF, flush_OFALU, flush_ALUMA, mcDone};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        RP1_OF = 5'd0; RP2_OF = 5'd0; rd_ALU = 5'd0;
        readsRP1_OF = 1'b0; readsRP2_OF = 1'b0;
        is_Ld_ALU = 1'b0; isWb_ALU = 1'b0;
        isBranchTaken_ALU = 1'b0; mcStart_ALU = 1'b0; clrCnt = 1'b0;
    endtask

    task automatic lu_in(input logic [4:0] rd);
        is_Ld_ALU = 1'b1; isWb_ALU = 1'b1; rd_ALU = rd;
        RP2_OF = rd; readsRP2_OF = 1'b1;
    endtask

    localparam logic [31:0] C_NONE = 32'b000_000_0;
    localparam logic [31:0] C_LU   = 32'b110_010_0;
    localparam logic [31:0] C_BR   = 32'b000_110_0;
    localparam logic [31:0] C_MC   = 32'b111_001_0;
    localparam logic [31:0] C_DONE = 32'b000_000_1;

    initial begin
        idle_in();
        rst_n = 1'b0;
        lu_in(5'd3);
        mcStart_ALU = 1'b1;
        tick(); tick();
        #3;
        chk("rst_ctl", ctl(), C_NONE);
        chk("rst_busy", {31'd0, mcBusy}, 32'd0);
        chk("rst_scnt", {28'd0, stallCount}, 32'd0);
        chk("rst_fcnt", {28'd0, flushCount}, 32'd0);
        idle_in();
        rst_n = 1'b1;
        tick();

        // Load-use via RP2: one stall cycle, then the load has moved on
        lu_in(5'd3);
        #3 chk("lu_ctl", ctl(), C_LU);
        tick();
        idle_in();
        #3 chk("lu_after_ctl", ctl(), C_NONE);
        chk("lu_scnt", {28'd0, stallCount}, 32'd1);
        tick();

        lu_in(5'd3); readsRP2_OF = 1'b0;
        #3 chk("lu_noread_ctl", ctl(), C_NONE);
        tick();
        idle_in();
        is_Ld_ALU = 1'b1; isWb_ALU = 1'b1; rd_ALU = 5'd9; RP1_OF = 5'd9; readsRP1_OF = 1'b1;
        #3 chk("lu_rp1_ctl", ctl(), C_LU);
        tick();
        idle_in();
        is_Ld_ALU = 1'b1; isWb_ALU = 1'b1; readsRP1_OF = 1'b1;
        #3 chk("lu_r0_ctl", ctl(), C_LU);
        tick();
        idle_in();
        lu_in(5'd7); isWb_ALU = 1'b0;
        #3 chk("lu_nowb_ctl", ctl(), C_NONE);
        tick();
        idle_in();
        #3 chk("lu3_scnt", {28'd0, stallCount}, 32'd3);

        // Branch overrides both load-use and multi-cycle start
        lu_in(5'd3); isBranchTaken_ALU = 1'b1; mcStart_ALU = 1'b1;
        #3 chk("br_ctl", ctl(), C_BR);
        tick();
        idle_in();
        #3 chk("br_fcnt", {28'd0, flushCount}, 32'd1);
        chk("br_scnt", {28'd0, stallCount}, 32'd3);
        chk("br_busy", {31'd0, mcBusy}, 32'd0);
        clrCnt = 1'b1;
        tick();
        idle_in();
        #3 chk("clr_scnt", {28'd0, stallCount}, 32'd0);
        chk("clr_fcnt", {28'd0, flushCount}, 32'd0);

        // Multi-cycle op: T..T+2 stall, T+3 done; hazards ignored while busy
        mcStart_ALU = 1'b1;
        #3 chk("mc_T_ctl", ctl(), C_MC);
        chk("mc_T_busy", {31'd0, mcBusy}, 32'd0);
        tick();
        #3 chk("mc_T1_ctl", ctl(), C_MC);
        chk("mc_T1_busy", {31'd0, mcBusy}, 32'd1);
        tick();
        lu_in(5'd4); isBranchTaken_ALU = 1'b1;
        #3 chk("mc_T2_ctl", ctl(), C_MC);
        tick();
        #3 chk("mc_T3_ctl", ctl(), C_DONE);
        chk("mc_T3_busy", {31'd0, mcBusy}, 32'd1);
        tick();
        idle_in();
        #3 chk("mc_T4_busy", {31'd0, mcBusy}, 32'd0);
        chk("mc_T4_ctl", ctl(), C_NONE);
        chk("mc_scnt", {28'd0, stallCount}, 32'd3);
        chk("mc_fcnt", {28'd0, flushCount}, 32'd0);

        // Back-to-back op is accepted straight from IDLE
        mcStart_ALU = 1'b1;
        #3 chk("mc2_T_ctl", ctl(), C_MC);
        tick();
        tick();
        // Now mcCnt==1: abandon the op with an asynchronous reset
        #3 chk("mc2_T2_ctl", ctl(), C_MC);
        rst_n = 1'b0;
        #1 chk("rstmid_ctl", ctl(), C_NONE);
        chk("rstmid_busy", {31'd0, mcBusy}, 32'd0);
        chk("rstmid_scnt", {28'd0, stallCount}, 32'd0);
        tick();
        #3 chk("rstmid_hold_ctl", ctl(), C_NONE);
        idle_in();
        rst_n = 1'b1;
        tick();
        #3 chk("rel_ctl", ctl(), C_NONE);
        chk("rel_busy", {31'd0, mcBusy}, 32'd0);

        // Saturation: 20 load-use cycles into a 4-bit counter
        for (int i = 0; i < 20; i++) begin
            lu_in(5'd12);
            tick();
        end
        idle_in();
        #3 chk("sat_scnt", {28'd0, stallCount}, 32'd15);
        chk("sat_fcnt", {28'd0, flushCount}, 32'd0);
        lu_in(5'd12); clrCnt = 1'b1;
        #3 chk("clr_lu_ctl", ctl(), C_LU);
        tick();
        idle_in();
        #3 chk("clr_win_scnt", {28'd0, stallCount}, 32'd0);
        lu_in(5'd12);
        tick();
        idle_in();
        #3 chk("post_clr_scnt", {28'd0, stallCount}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
